dram_prefetch_capture: RTL and testbench
========================================

DRAM_PREFETCH_CAPTURE -- requirements
Module: dram_prefetch_capture

Interface
REQ-001 SHALL have parameter AXNUM, default 24: antenna sample width.
REQ-002 SHALL have parameter ABITS, default 21: MCB word-address width; buffer depth is 2^ABITS words.
REQ-003 SHALL have port clock_i, input, 1: sole clock; all logic on its rising edge (one clock, no CDC).
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port capture_i, input, 1: acquisition enable, level.
REQ-006 SHALL have ports strobe_i (input, 1) and signal_i (input, AXNUM): sample-valid pulse and sample.
REQ-007 SHALL have port data_sent_i, input, 1: one-cycle pulse; consumer has taken fetched_data_o.
REQ-008 SHALL have ports fetched_data_o (output, AXNUM) and fetched_valid_o (output, 1): read-back word and its valid flag.
REQ-009 SHALL have ports mcb_ce_o, mcb_wr_o (output, 1 each), mcb_adr_o (output, ABITS) and mcb_dat_o (output, 32): MCB command, write flag, address, write data.
REQ-010 SHALL have ports mcb_rdy_i, mcb_ack_i (input, 1 each) and mcb_dat_i (input, 32): MCB accepts commands, read data valid, read data.
REQ-011 SHALL have ports state_o (output, 3: capture state) and overflow_o (output, 1: sticky sample-drop flag).

Function
REQ-012 SHALL implement states IDLE=0, FILL=1, FULL=2, READ=3, WAIT=4, presented on state_o.
REQ-013 SHALL, in IDLE, clear the write address, read address, pending flag and prefetch buffers, and move to FILL when capture_i=1.
REQ-014 SHALL, in FILL, latch signal_i into a one-entry pending register on strobe_i.
REQ-015 SHALL issue a write when pending=1 and mcb_rdy_i=1: one cycle of mcb_ce_o=1, mcb_wr_o=1, mcb_adr_o=write address, mcb_dat_o=signal zero-extended to 32 bits.
REQ-016 SHALL increment the write address after each issued write.
REQ-017 SHALL, when strobe_i arrives while pending=1 and no write issues that cycle, overwrite the pending sample and set overflow_o.
REQ-018 SHALL, when strobe_i and a write issue in the same cycle, write the old sample and latch the new one, with no overflow.
REQ-019 SHALL move FILL->FULL on the cycle the write to address 2^ABITS-1 issues; FULL->READ unconditionally one cycle later, with the read address set to 0.
REQ-020 SHALL, in READ, when the internal request is set and mcb_rdy_i=1, issue one read (mcb_ce_o=1, mcb_wr_o=0, mcb_adr_o=read address), increment the read address modulo 2^ABITS, and go to WAIT.
REQ-021 SHALL return WAIT->READ on mcb_ack_i.
REQ-022 SHALL hold mcb_ce_o=0 in every other cycle, and drive mcb_dat_o=0 and mcb_adr_o=0 when not writing or reading.
REQ-023 SHALL implement the prefetch as two stages: output register (fetched_data_o/fetched_valid_o) and one buffer word (data + valid).
REQ-024 SHALL set the internal request while state is READ, the buffer is empty and no read is outstanding.
REQ-025 SHALL, on mcb_ack_i, load mcb_dat_i[AXNUM-1:0] into the output register if fetched_valid_o=0, else into the buffer.
REQ-026 SHALL, on data_sent_i, move the buffer into the output register (fetched_valid_o = old buffer valid) and clear the buffer.
REQ-027 SHALL, when data_sent_i and mcb_ack_i coincide, load the output register from the buffer if the buffer is valid and put the new word into the buffer; if the buffer is empty, load the output register directly from mcb_dat_i.
REQ-028 SHALL ignore data_sent_i while fetched_valid_o=0.
REQ-029 SHALL ignore mcb_ack_i outside WAIT.
REQ-030 SHALL, when capture_i=0 in any state, go to IDLE next cycle; an outstanding read is abandoned and its late ack is dropped.

Reset
REQ-031 SHALL, while reset_i=0, set state IDLE, clear both addresses, pending, buffer and output register, and hold overflow_o, mcb_ce_o, mcb_wr_o and fetched_valid_o at 0, with all data outputs 0.
REQ-032 SHALL clear overflow_o only by reset.

Structure
REQ-033 SHALL place the state encodings (IDLE..WAIT) and the MCB data width (32) in a shared package.
REQ-034 SHALL implement the prefetch (REQ-023..029) as one sub-module, prefetch_buffer, parameterised by AXNUM.

Verification
REQ-035 SHALL cover, with ABITS=3, mcb_rdy_i=1 and capture_i=1: 8 strobes of 0x000001..0x000008 -> 8 writes to addresses 0..7, state_o 1->2->3, overflow_o=0.
REQ-036 SHALL cover, with mcb_rdy_i=0 and two strobes (0xAAAAAA then 0x555555), then mcb_rdy_i=1 -> a single write of 0x555555 and overflow_o=1.
REQ-037 SHALL cover READ with a one-cycle-later ack returning 0x00ABCDEF -> fetched_data_o=0xABCDEF and fetched_valid_o=1, a second read fills the buffer, and no third request until data_sent_i.
REQ-038 SHALL cover reads continuing past address 7 -> the next read is at address 0.
REQ-039 SHALL cover capture_i dropped while in WAIT -> IDLE next cycle, the later mcb_ack_i ignored, and fetched_valid_o=0.
REQ-040 SHALL cover reset_i=0 mid-FILL -> state_o=0, mcb_ce_o=0 and overflow_o=0 on the next edge.

Source files
------------

// File: rtl/dram_prefetch_capture_pkg.sv
// Shared definitions for the DRAM capture/read-back block: FSM encodings and MCB data width.
package dram_prefetch_capture_pkg;

    localparam int unsigned McbDataWidth = 32;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StFill = 3'd1,
        StFull = 3'd2,
        StRead = 3'd3,
        StWait = 3'd4
    } capture_state_e;

endpackage

// File: rtl/prefetch_buffer.sv
// Two-stage read-back prefetch: an output register plus one buffer word.
// The read request is raised only when the buffer can absorb the next word.
module prefetch_buffer #(
    parameter int unsigned AXNUM = 24
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             read_state_i,
    input  logic             outstanding_i,
    input  logic             ack_i,
    input  logic [AXNUM-1:0] ack_data_i,
    input  logic             data_sent_i,
    output logic             request_o,
    output logic [AXNUM-1:0] fetched_data_o,
    output logic             fetched_valid_o
);

    logic [AXNUM-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [AXNUM-1:0] buf_data_q, buf_data_d;
    logic             buf_valid_q, buf_valid_d;
    logic             sent;

    // data_sent_i is meaningless while nothing is presented
    assign sent = data_sent_i && out_valid_q;

    // Next-state for output register and buffer word
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        if (clear_i) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            buf_data_d  = '0;
            buf_valid_d = 1'b0;
        end else if (sent && ack_i) begin
            if (buf_valid_q) begin
                out_data_d  = buf_data_q;
                out_valid_d = 1'b1;
                buf_data_d  = ack_data_i;
                buf_valid_d = 1'b1;
            end else begin
                out_data_d  = ack_data_i;
                out_valid_d = 1'b1;
            end
        end else if (sent) begin
            out_data_d  = buf_data_q;
            out_valid_d = buf_valid_q;
            buf_data_d  = '0;
            buf_valid_d = 1'b0;
        end else if (ack_i) begin
            if (!out_valid_q) begin
                out_data_d  = ack_data_i;
                out_valid_d = 1'b1;
            end else begin
                buf_data_d  = ack_data_i;
                buf_valid_d = 1'b1;
            end
        end
    end

    // Register stage with synchronous active-low reset
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            buf_data_q  <= buf_data_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign request_o       = read_state_i && !buf_valid_q && !outstanding_i;
    assign fetched_data_o  = out_data_q;
    assign fetched_valid_o = out_valid_q;

endmodule

// File: rtl/dram_prefetch_capture.sv
// Captures antenna samples into DRAM through the MCB until the buffer is full,
// then reads it back continuously through a two-word prefetch.
module dram_prefetch_capture
    import dram_prefetch_capture_pkg::*;
#(
    parameter int unsigned AXNUM = 24,
    parameter int unsigned ABITS = 21
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    capture_i,
    input  logic                    strobe_i,
    input  logic [AXNUM-1:0]        signal_i,
    input  logic                    data_sent_i,
    output logic [AXNUM-1:0]        fetched_data_o,
    output logic                    fetched_valid_o,
    output logic                    mcb_ce_o,
    output logic                    mcb_wr_o,
    output logic [ABITS-1:0]        mcb_adr_o,
    output logic [McbDataWidth-1:0] mcb_dat_o,
    input  logic                    mcb_rdy_i,
    input  logic                    mcb_ack_i,
    input  logic [McbDataWidth-1:0] mcb_dat_i,
    output logic [2:0]              state_o,
    output logic                    overflow_o
);

    capture_state_e   state_q;
    logic [ABITS-1:0] wr_adr_q;
    logic [ABITS-1:0] rd_adr_q;
    logic             pend_valid_q;
    logic [AXNUM-1:0] pend_data_q;
    logic             overflow_q;

    logic wr_issue;
    logic rd_issue;
    logic rd_request;
    logic ack_valid;
    logic pf_clear;
    logic unused_mcb_dat;

    // Commands are never issued in reset or once capture has been dropped
    assign wr_issue  = reset_i && capture_i && (state_q == StFill) && pend_valid_q && mcb_rdy_i;
    assign rd_issue  = reset_i && capture_i && rd_request && mcb_rdy_i;
    // Acks outside WAIT belong to abandoned reads
    assign ack_valid = capture_i && (state_q == StWait) && mcb_ack_i;
    assign pf_clear  = (state_q == StIdle) || !capture_i;

    assign unused_mcb_dat = ^mcb_dat_i;

    prefetch_buffer #(
        .AXNUM (AXNUM)
    ) u_prefetch_buffer (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .clear_i         (pf_clear),
        .read_state_i    (state_q == StRead),
        .outstanding_i   (state_q == StWait),
        .ack_i           (ack_valid),
        .ack_data_i      (mcb_dat_i[AXNUM-1:0]),
        .data_sent_i     (data_sent_i),
        .request_o       (rd_request),
        .fetched_data_o  (fetched_data_o),
        .fetched_valid_o (fetched_valid_o)
    );

    // Capture FSM with write/read address counters, pending sample and sticky overflow
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q      <= StIdle;
            wr_adr_q     <= '0;
            rd_adr_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            overflow_q   <= 1'b0;
        end else if (!capture_i) begin
            state_q      <= StIdle;
            wr_adr_q     <= '0;
            rd_adr_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    wr_adr_q     <= '0;
                    rd_adr_q     <= '0;
                    pend_valid_q <= 1'b0;
                    pend_data_q  <= '0;
                    state_q      <= StFill;
                end
                StFill: begin
                    if (strobe_i) begin
                        pend_data_q  <= signal_i;
                        pend_valid_q <= 1'b1;
                        // Old sample lost only if it could not be written this cycle
                        if (pend_valid_q && !wr_issue) begin
                            overflow_q <= 1'b1;
                        end
                    end else if (wr_issue) begin
                        pend_valid_q <= 1'b0;
                    end
                    if (wr_issue) begin
                        wr_adr_q <= wr_adr_q + ABITS'(1);
                        if (wr_adr_q == {ABITS{1'b1}}) begin
                            state_q <= StFull;
                        end
                    end
                end
                StFull: begin
                    rd_adr_q <= '0;
                    state_q  <= StRead;
                end
                StRead: begin
                    if (rd_issue) begin
                        rd_adr_q <= rd_adr_q + ABITS'(1);
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (mcb_ack_i) begin
                        state_q <= StRead;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mcb_ce_o   = wr_issue || rd_issue;
    assign mcb_wr_o   = wr_issue;
    assign mcb_adr_o  = wr_issue ? wr_adr_q : (rd_issue ? rd_adr_q : '0);
    assign mcb_dat_o  = wr_issue ? McbDataWidth'(pend_data_q) : '0;
    assign state_o    = state_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_dram_prefetch_capture.sv
// Scoreboard bench for dram_prefetch_capture with an 8-word buffer (ABITS=3).
module tb_dram_prefetch_capture;

    localparam int unsigned AXNUM = 24;
    localparam int unsigned ABITS = 3;

    logic             clock;
    logic             reset;
    logic             capture;
    logic             strobe;
    logic [AXNUM-1:0] signal;
    logic             data_sent;
    logic [AXNUM-1:0] fetched_data;
    logic             fetched_valid;
    logic             mcb_ce;
    logic             mcb_wr;
    logic [ABITS-1:0] mcb_adr;
    logic [31:0]      mcb_dat_out;
    logic             mcb_rdy;
    logic             mcb_ack;
    logic [31:0]      mcb_dat_in;
    logic [2:0]       state;
    logic             overflow;

    dram_prefetch_capture #(
        .AXNUM (AXNUM),
        .ABITS (ABITS)
    ) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .capture_i       (capture),
        .strobe_i        (strobe),
        .signal_i        (signal),
        .data_sent_i     (data_sent),
        .fetched_data_o  (fetched_data),
        .fetched_valid_o (fetched_valid),
        .mcb_ce_o        (mcb_ce),
        .mcb_wr_o        (mcb_wr),
        .mcb_adr_o       (mcb_adr),
        .mcb_dat_o       (mcb_dat_out),
        .mcb_rdy_i       (mcb_rdy),
        .mcb_ack_i       (mcb_ack),
        .mcb_dat_i       (mcb_dat_in),
        .state_o         (state),
        .overflow_o      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Field selectors for status expectations
    localparam int SelState  = 0;
    localparam int SelOvf    = 1;
    localparam int SelCe     = 2;
    localparam int SelFValid = 3;
    localparam int SelFData  = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t              chk_q[$];
    logic [35:0]       exp_cmd_q[$];
    logic [AXNUM-1:0]  exp_fetch_q[$];
    int                n_vec = 0;
    int                n_err = 0;
    bit                end_req = 1'b0;
    bit                end_done = 1'b0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SelState:  return {29'd0, state};
            SelOvf:    return {31'd0, overflow};
            SelCe:     return {31'd0, mcb_ce};
            SelFValid: return {31'd0, fetched_valid};
            default:   return {8'd0, fetched_data};
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = val;
        chk_q.push_back(c);
    endtask

    task automatic push_cmd(input logic wr, input logic [ABITS-1:0] adr, input logic [31:0] dat);
        exp_cmd_q.push_back({wr, adr, dat});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: all comparisons happen here, mid-cycle on the falling edge
    initial begin
        logic [35:0]      got_cmd;
        logic [35:0]      exp_cmd;
        logic [AXNUM-1:0] exp_f;
        logic [31:0]      act;
        chk_t             c;
        forever begin
            @(negedge clock);
            while (chk_q.size() > 0) begin
                c   = chk_q.pop_front();
                act = actual(c.sel);
                n_vec++;
                if (act !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h, expected %0h", c.name, act, c.exp);
                end
            end
            if (mcb_ce === 1'b1) begin
                got_cmd = {mcb_wr, mcb_adr, mcb_dat_out};
                n_vec++;
                if (exp_cmd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_cmd: got wr=%0b adr=%0h dat=%0h, expected none",
                             mcb_wr, mcb_adr, mcb_dat_out);
                end else begin
                    exp_cmd = exp_cmd_q.pop_front();
                    if (got_cmd !== exp_cmd) begin
                        n_err++;
                        $display("FAIL mcb_cmd: got wr=%0b adr=%0h dat=%0h, expected wr=%0b adr=%0h dat=%0h",
                                 got_cmd[35], got_cmd[34:32], got_cmd[31:0],
                                 exp_cmd[35], exp_cmd[34:32], exp_cmd[31:0]);
                    end
                end
            end
            if (fetched_valid === 1'b1 && data_sent === 1'b1) begin
                n_vec++;
                if (exp_fetch_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_fetch: got %0h, expected none", fetched_data);
                end else begin
                    exp_f = exp_fetch_q.pop_front();
                    if (fetched_data !== exp_f) begin
                        n_err++;
                        $display("FAIL fetched_word: got %0h, expected %0h", fetched_data, exp_f);
                    end
                end
            end
            if (end_req && !end_done) begin
                end_done = 1'b1;
                n_vec++;
                if (exp_cmd_q.size() != 0) begin
                    n_err++;
                    $display("FAIL missing_cmds: got %0d left, expected 0", exp_cmd_q.size());
                end
                n_vec++;
                if (exp_fetch_q.size() != 0) begin
                    n_err++;
                    $display("FAIL missing_fetch: got %0d left, expected 0", exp_fetch_q.size());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Stimulus: directed sequence, inputs change 1 time unit after the rising edge
    initial begin
        reset      = 1'b0;
        capture    = 1'b0;
        strobe     = 1'b0;
        signal     = '0;
        data_sent  = 1'b0;
        mcb_rdy    = 1'b1;
        mcb_ack    = 1'b0;
        mcb_dat_in = '0;
        tick();
        tick();
        tick();
        expect_val("reset_state", SelState, 32'd0);
        expect_val("reset_ce", SelCe, 32'd0);
        expect_val("reset_ovf", SelOvf, 32'd0);
        expect_val("reset_fvalid", SelFValid, 32'd0);
        expect_val("reset_fdata", SelFData, 32'd0);
        tick();
        reset   = 1'b1;
        capture = 1'b1;
        tick();
        expect_val("enter_fill", SelState, 32'd1);

        // Back-to-back strobes: each write lands the cycle after its strobe
        for (int i = 1; i <= 8; i++) begin
            strobe = 1'b1;
            signal = AXNUM'(i);
            push_cmd(1'b1, ABITS'(i - 1), 32'(i));
            tick();
        end
        strobe = 1'b0;
        expect_val("fill_last_write", SelState, 32'd1);
        tick();
        mcb_rdy = 1'b0;
        expect_val("full_state", SelState, 32'd2);
        tick();
        expect_val("read_state", SelState, 32'd3);
        expect_val("fill_no_ovf", SelOvf, 32'd0);
        expect_val("read_stalled_ce", SelCe, 32'd0);

        // First read -> output register, second read -> buffer
        tick();
        mcb_rdy = 1'b1;
        push_cmd(1'b0, 3'd0, 32'd0);
        tick();
        mcb_ack    = 1'b1;
        mcb_dat_in = 32'h00AB_CDEF;
        exp_fetch_q.push_back(24'hABCDEF);
        expect_val("wait_state", SelState, 32'd4);
        tick();
        mcb_ack    = 1'b0;
        mcb_dat_in = '0;
        push_cmd(1'b0, 3'd1, 32'd0);
        expect_val("first_fvalid", SelFValid, 32'd1);
        expect_val("first_fdata", SelFData, 32'h00AB_CDEF);
        tick();
        mcb_ack    = 1'b1;
        mcb_dat_in = 32'h0012_3456;
        exp_fetch_q.push_back(24'h123456);
        tick();
        mcb_ack    = 1'b0;
        mcb_dat_in = '0;
        expect_val("buf_full_no_req0", SelCe, 32'd0);
        expect_val("buf_full_state", SelState, 32'd3);
        tick();
        expect_val("buf_full_no_req1", SelCe, 32'd0);
        tick();
        expect_val("buf_full_no_req2", SelCe, 32'd0);
        expect_val("buf_full_fdata", SelFData, 32'h00AB_CDEF);
        expect_val("buf_full_fvalid", SelFValid, 32'd1);
        tick();
        data_sent = 1'b1;
        tick();
        data_sent = 1'b0;
        expect_val("shift_fvalid", SelFValid, 32'd1);
        expect_val("shift_fdata", SelFData, 32'h0012_3456);

        // Streaming reads at 2..7 then wrap to 0; ack and data_sent coincide
        for (int k = 0; k < 7; k++) begin
            push_cmd(1'b0, ABITS'((2 + k) % 8), 32'd0);
            tick();
            mcb_ack    = 1'b1;
            mcb_dat_in = 32'h00C0_0000 + 32'(k);
            data_sent  = 1'b1;
            exp_fetch_q.push_back(24'hC00000 + AXNUM'(k));
            tick();
            mcb_ack    = 1'b0;
            mcb_dat_in = '0;
            data_sent  = 1'b0;
        end

        // Last streamed word is discarded by the capture drop below
        void'(exp_fetch_q.pop_back());
        push_cmd(1'b0, 3'd1, 32'd0);
        expect_val("pre_drop_fvalid", SelFValid, 32'd1);
        tick();
        capture = 1'b0;
        expect_val("drop_in_wait", SelState, 32'd4);
        tick();
        mcb_ack    = 1'b1;
        mcb_dat_in = 32'h00FF_FFFF;
        expect_val("drop_idle", SelState, 32'd0);
        expect_val("drop_fvalid", SelFValid, 32'd0);
        tick();
        mcb_ack    = 1'b0;
        mcb_dat_in = '0;
        mcb_rdy    = 1'b0;
        expect_val("late_ack_fvalid", SelFValid, 32'd0);
        expect_val("late_ack_fdata", SelFData, 32'd0);
        expect_val("late_ack_state", SelState, 32'd0);

        // Overflow: two strobes while the MCB is busy
        tick();
        capture = 1'b1;
        tick();
        strobe = 1'b1;
        signal = 24'hAAAAAA;
        expect_val("refill_state", SelState, 32'd1);
        tick();
        signal = 24'h555555;
        expect_val("ovf_before", SelOvf, 32'd0);
        tick();
        strobe  = 1'b0;
        mcb_rdy = 1'b1;
        push_cmd(1'b1, 3'd0, 32'h0055_5555);
        expect_val("ovf_set", SelOvf, 32'd1);
        tick();
        mcb_rdy = 1'b0;
        strobe  = 1'b1;
        signal  = 24'h000123;
        expect_val("ovf_single_write", SelCe, 32'd0);
        expect_val("ovf_sticky", SelOvf, 32'd1);

        // Reset mid-FILL with a write otherwise ready to go
        tick();
        strobe  = 1'b0;
        reset   = 1'b0;
        mcb_rdy = 1'b1;
        expect_val("reset_blocks_ce", SelCe, 32'd0);
        tick();
        expect_val("midfill_reset_state", SelState, 32'd0);
        expect_val("midfill_reset_ce", SelCe, 32'd0);
        expect_val("midfill_reset_ovf", SelOvf, 32'd0);
        tick();
        reset   = 1'b1;
        capture = 1'b0;
        tick();
        end_req = 1'b1;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
